// File: rtl/bus_arbiter.sv
// bus_arbiter: two-master bus arbiter with one-cycle grant latency,
// last-grant tie breaking and a bounded hold time under contention.
//
// Ports:
//   clk, reset                    single clock, synchronous active-high reset
//   m0_req/m1_req                 bus requests from master 0 / master 1
//   m0_wr/m1_wr                   write enables from the masters
//   m0_address/m1_address [AW]    addresses from the masters
//   m0_dout/m1_dout [DW]          write data from the masters
//   m0_grant/m1_grant             registered grants
//   m_req, m_wr, m_address, m_dout  muxed request/command of the granted master
//                                   toward the address decoder (0 when idle)
module bus_arbiter #(
  parameter int AW       = 16,
  parameter int DW       = 32,
  parameter int HOLD_MAX = 16
) (
  input  logic          clk,
  input  logic          reset,
  input  logic          m0_req,
  input  logic          m1_req,
  input  logic          m0_wr,
  input  logic          m1_wr,
  input  logic [AW-1:0] m0_address,
  input  logic [AW-1:0] m1_address,
  input  logic [DW-1:0] m0_dout,
  input  logic [DW-1:0] m1_dout,
  output logic          m0_grant,
  output logic          m1_grant,
  output logic          m_req,
  output logic          m_wr,
  output logic [AW-1:0] m_address,
  output logic [DW-1:0] m_dout
);

  localparam int CW = (HOLD_MAX > 1) ? $clog2(HOLD_MAX) : 1;
  localparam logic [CW-1:0] HOLD_LAST = CW'(HOLD_MAX - 1);

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    GRANT0 = 2'd1,
    GRANT1 = 2'd2
  } state_t;

  state_t        state;
  state_t        next;
  logic [CW-1:0] hold_cnt;
  logic          last_grant;
  logic          sel0;
  logic          sel1;

  always_comb begin
    next = state;
    case (state)
      IDLE: begin
        // last_grant resets to 1, so master 0 wins the first tie.
        if (m0_req && m1_req) next = last_grant ? GRANT0 : GRANT1;
        else if (m0_req)      next = GRANT0;
        else if (m1_req)      next = GRANT1;
      end
      GRANT0: begin
        if (!m0_req)                               next = m1_req ? GRANT1 : IDLE;
        else if (m1_req && (hold_cnt == HOLD_LAST)) next = GRANT1;
      end
      GRANT1: begin
        if (!m1_req)                               next = m0_req ? GRANT0 : IDLE;
        else if (m0_req && (hold_cnt == HOLD_LAST)) next = GRANT0;
      end
      default: next = IDLE;
    endcase
  end

  // State, grants, hold counter and last_grant all register together;
  // the counter restarts on any state change and saturates while staying.
  always_ff @(posedge clk) begin
    if (reset) begin
      state      <= IDLE;
      hold_cnt   <= '0;
      last_grant <= 1'b1;
      m0_grant   <= 1'b0;
      m1_grant   <= 1'b0;
    end else begin
      state    <= next;
      m0_grant <= (next == GRANT0);
      m1_grant <= (next == GRANT1);
      if (next == IDLE || next != state) hold_cnt <= '0;
      else if (hold_cnt != HOLD_LAST)    hold_cnt <= hold_cnt + 1'b1;
      if (next == GRANT0 && state != GRANT0) last_grant <= 1'b0;
      if (next == GRANT1 && state != GRANT1) last_grant <= 1'b1;
    end
  end

  // Downstream outputs are forced quiet while reset is high, even if the
  // state register still holds a grant from before reset was raised.
  assign sel0 = (state == GRANT0) && !reset;
  assign sel1 = (state == GRANT1) && !reset;

  always_comb begin
    m_req     = (sel0 & m0_req) | (sel1 & m1_req);
    m_wr      = 1'b0;
    m_address = '0;
    m_dout    = '0;
    if (sel0) begin
      m_wr      = m0_wr & m_req;
      m_address = m0_address;
      m_dout    = m0_dout;
    end else if (sel1) begin
      m_wr      = m1_wr & m_req;
      m_address = m1_address;
      m_dout    = m1_dout;
    end
  end

endmodule

// File: doc/bus_arbiter.md
BUS_ARBITER -- requirements
Module: bus_arbiter

Interface
REQ-001 SHALL have parameter AW, default 16, meaning address width.
REQ-002 SHALL have parameter DW, default 32, meaning write-data width.
REQ-003 SHALL have parameter HOLD_MAX, default 16, meaning the maximum number of consecutive grant cycles while the other master is requesting.
REQ-004 SHALL have port clk  input  1  single clock; all state updates on rising edge.
REQ-005 SHALL have port reset  input  1  synchronous, active-high reset.
REQ-006 SHALL have ports m0_req / m1_req  input  1  bus request from master 0 / master 1.
REQ-007 SHALL have ports m0_wr / m1_wr  input  1  write enable from master 0 / master 1.
REQ-008 SHALL have ports m0_address / m1_address  input  AW  address from master 0 / master 1.
REQ-009 SHALL have ports m0_dout / m1_dout  input  DW  write data from master 0 / master 1.
REQ-010 SHALL have ports m0_grant / m1_grant  output  1  registered grant to master 0 / master 1.
REQ-011 SHALL have port m_req  output  1  request to the downstream address decoder.
REQ-012 SHALL have port m_wr  output  1  write enable of the granted master.
REQ-013 SHALL have port m_address  output  AW  address of the granted master, driving the decoder's s_address.
REQ-014 SHALL have port m_dout  output  DW  write data of the granted master.

Function
REQ-015 SHALL implement an FSM with states IDLE, GRANT0 and GRANT1, plus a 1-bit last_grant register and a hold_cnt counter of width clog2(HOLD_MAX).
REQ-016 SHALL drive m0_grant=1 only in GRANT0 and m1_grant=1 only in GRANT1, and SHALL never assert both grants in the same cycle.
REQ-017 SHALL sample requests at edge n and present the resulting grant in cycle n+1, giving a one-cycle grant latency.
REQ-018 IDLE: with only one request, SHALL go to that master's GRANT state; with both requests, SHALL grant the master that is not last_grant; with no request, SHALL stay in IDLE.
REQ-019 GRANTx: when mx_req deasserts and the other master is requesting, SHALL move directly to the other GRANT state with no IDLE bubble.
REQ-020 GRANTx: when mx_req deasserts and the other master is not requesting, SHALL go to IDLE.
REQ-021 GRANTx: while mx_req is held, hold_cnt SHALL increment each cycle and saturate at HOLD_MAX-1.
REQ-022 GRANTx: when hold_cnt==HOLD_MAX-1, mx_req is high and the other master is requesting, SHALL force a handoff to the other GRANT state.
REQ-023 GRANTx: when hold_cnt==HOLD_MAX-1 and the other master is not requesting, SHALL stay in GRANTx with hold_cnt held at saturation.
REQ-024 SHALL clear hold_cnt to 0 on every entry to a GRANT state and in IDLE.
REQ-025 SHALL update last_grant to x on every entry to GRANTx, and SHALL leave it unchanged in IDLE.
REQ-026 SHALL generate m_req combinationally as (GRANT0 & m0_req) | (GRANT1 & m1_req).
REQ-027 SHALL drive m_wr, m_address and m_dout combinationally from the granted master, and SHALL drive them to 0 in IDLE.
REQ-028 SHALL gate m_wr with m_req, so a granted master that has dropped its request issues no write.
REQ-029 SHALL pass m_address through unmodified; address range checking belongs to the downstream decoder.

Reset
REQ-030 When reset=1 at a clock edge, SHALL set state to IDLE, hold_cnt to 0, last_grant to 1, and m0_grant and m1_grant to 0.
REQ-031 The reset state SHALL cause master 0 to win the first tie after reset.
REQ-032 While in reset, m_req, m_wr, m_address and m_dout SHALL all be 0.
REQ-033 When reset is asserted mid-grant, SHALL drop the grant in the following cycle regardless of requests, with no partial handoff.
REQ-034 In the first cycle after reset deasserts, SHALL evaluate requests from IDLE.

Verification
REQ-035 Scenario: after reset, m0_req=1, m0_address=16'h0010, m0_wr=1 at cycle 2 -> m0_grant=1 at cycle 3, m_req=1, m_address=16'h0010, m_wr=1.
REQ-036 Scenario: both requests rise together after reset -> GRANT0; when m0_req drops at cycle k -> m1_grant=1 at cycle k+1, m1_address on m_address, and no idle cycle between grants.
REQ-037 Scenario: both requests held continuously with HOLD_MAX=16 -> grants alternate, each held exactly 16 cycles (0,1,0,1...).
REQ-038 Scenario: m1_req alone held for 40 cycles -> m1_grant stays 1 throughout and hold_cnt saturates at 15.
REQ-039 Scenario: reset pulsed during GRANT1 -> next cycle both grants=0, m_req=0, m_address=0; then a tie from both requests goes to m0.
REQ-040 Scenario: no requests -> IDLE with m_req=0, m_address=0 and m_dout=0; granted master drops its request for one cycle -> m_req=0 and m_wr=0 that cycle.
